// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
// Shares the single register-file write port between the W stage (fixed
// priority) and a buffered secondary writer (MDU / late load return).
// Secondary writes wait in a DEPTH-entry FIFO; a starvation counter forces
// a one-cycle pipeline stall so a queued write cannot wait forever.
// Optional feature macro: RF_WPORT_TRACE_EN (prints every RF write).
module rf_wport_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   w_we,
    input  logic [4:0]             w_a3,
    input  logic [31:0]            w_wd,
    input  logic [31:0]            w_pc,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [4:0]             s_a3,
    input  logic [31:0]            s_wd,
    input  logic [31:0]            s_pc,
    output logic                   rf_we,
    output logic [4:0]             rf_a3,
    output logic [31:0]            rf_wd,
    output logic [31:0]            rf_pc,
    output logic                   w_stall,
    input  logic [4:0]             q_a1,
    input  logic [4:0]             q_a2,
    output logic                   q_busy1,
    output logic                   q_busy2,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        BLOCKED = 2'd2,
        FORCE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_nstate;

    logic [4:0]      r_a3_mem [DEPTH];
    logic [31:0]     r_wd_mem [DEPTH];
    logic [31:0]     r_pc_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_starve;
    logic            r_stall;

    logic            w_full;
    logic            w_empty;
    logic            w_s_ready;
    logic            w_push;
    logic            w_wvalid;
    logic            w_grant_w;
    logic            w_pop;
    logic            w_blocked;
    logic [CW-1:0]   w_cnt_nxt;
    logic [7:0]      w_starve_nxt;
    logic [DEPTH-1:0] w_ent_vld;
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_hit2;

    // Handshake and grant decisions. Acceptance uses only the registered
    // count so s_ready never depends on this cycle's W request.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_s_ready = reset && !w_full;
    assign w_push    = s_valid && w_s_ready && (s_a3 != 5'd0);
    // A stalled pipeline re-presents its instruction next cycle, so the W
    // request is ignored while w_stall is high.
    assign w_wvalid  = w_we && (w_a3 != 5'd0) && !r_stall;
    assign w_grant_w = reset && w_wvalid;
    assign w_pop     = reset && !w_wvalid && !w_empty;
    assign w_blocked = w_grant_w && !w_empty;
    assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

    assign s_ready   = w_s_ready;
    assign w_stall   = r_stall;
    assign q_count   = r_count;

    // Write-port mux: W stage first, then FIFO head; zeros when idle.
    always_comb begin
        rf_we = 1'b0;
        rf_a3 = 5'd0;
        rf_wd = 32'd0;
        rf_pc = 32'd0;
        if (w_grant_w) begin
            rf_we = 1'b1;
            rf_a3 = w_a3;
            rf_wd = w_wd;
            rf_pc = w_pc;
        end else if (w_pop) begin
            rf_we = 1'b1;
            rf_a3 = r_a3_mem[r_rptr];
            rf_wd = r_wd_mem[r_rptr];
            rf_pc = r_pc_mem[r_rptr];
        end
    end

    // FIFO storage; contents outside the valid window are don't-care.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_a3_mem[r_wptr] <= s_a3;
            r_wd_mem[r_wptr] <= s_wd;
            r_pc_mem[r_wptr] <= s_pc;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_cnt_nxt;
        end
    end

    // Starvation counter: counts cycles where W keeps a queued entry waiting.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_pop || w_empty) begin
            w_starve_nxt = 8'd0;
        end else if (w_blocked && (r_starve < 8'(STARVE_LIMIT))) begin
            w_starve_nxt = r_starve + 8'd1;
        end
    end

    // Next-state logic; FORCE lasts exactly one cycle since it always pops.
    always_comb begin
        w_nstate = r_state;
        case (r_state)
            IDLE: begin
                if (w_push) w_nstate = DRAIN;
            end
            DRAIN, BLOCKED: begin
                if (w_cnt_nxt == '0)
                    w_nstate = IDLE;
                else if (w_starve_nxt == 8'(STARVE_LIMIT))
                    w_nstate = FORCE;
                else if (w_blocked)
                    w_nstate = BLOCKED;
                else
                    w_nstate = DRAIN;
            end
            FORCE: begin
                w_nstate = (w_cnt_nxt == '0) ? IDLE : DRAIN;
            end
            default: w_nstate = IDLE;
        endcase
    end

    // State, starvation count and the registered stall output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_starve <= 8'd0;
            r_stall  <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_starve <= w_starve_nxt;
            r_stall  <= (w_nstate == FORCE);
        end
    end

    // Hazard query: which FIFO slots hold live entries, and do they match.
    always_comb begin
        w_ent_vld = '0;
        w_hit1    = '0;
        w_hit2    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent_vld[i] = (CW'(AW'(AW'(i) - r_rptr)) < r_count);
            w_hit1[i]    = w_ent_vld[i] && (r_a3_mem[i] == q_a1);
            w_hit2[i]    = w_ent_vld[i] && (r_a3_mem[i] == q_a2);
        end
    end

    assign q_busy1 = reset && (q_a1 != 5'd0) && (|w_hit1);
    assign q_busy2 = reset && (q_a2 != 5'd0) && (|w_hit2);

`ifdef RF_WPORT_TRACE_EN
    // Write trace for simulation logs.
    always @(posedge clk) begin
        if (reset && rf_we)
            $display("%d@%h: $%d <= %h", $time, rf_pc, rf_a3, rf_wd);
    end
`else
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: a queue-based reference model
// predicts each cycle's port owner and status; a negedge monitor compares.
module tb_rf_wport_arbiter;

    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w_we = 1'b0;
    logic [4:0]  w_a3 = '0;
    logic [31:0] w_wd = '0, w_pc = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [4:0]  s_a3 = '0;
    logic [31:0] s_wd = '0, s_pc = '0;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd, rf_pc;
    logic        w_stall;
    logic [4:0]  q_a1 = '0, q_a2 = '0;
    logic        q_busy1, q_busy2;
    logic [2:0]  q_count;

    rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_a3(s_a3), .s_wd(s_wd), .s_pc(s_pc),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_pc(rf_pc),
        .w_stall(w_stall),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } wr_t;

    typedef struct {
        bit rdy;
        bit stall;
        int cnt;
        bit b1;
        bit b2;
        bit we;
    } st_t;

    wr_t mq[$];      // model of the pending secondary writes, oldest first
    wr_t exp_q[$];   // expected RF writes, in order
    st_t st_q[$];    // expected per-cycle status
    bit  mstall = 0;
    int  mrun = 0;   // consecutive cycles the queue head lost to W

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].a3 == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle of stimulus; the model predicts what the DUT shows in it.
    task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wdat,
                       input logic [31:0] wpc, input bit sv, input logic [4:0] sa,
                       input logic [31:0] sdat, input logic [31:0] spc,
                       input logic [4:0] a1, input logic [4:0] a2);
        st_t st;
        wr_t e;
        bit  wv, popped;
        @(posedge clk);
        #1;
        w_we = we; w_a3 = wa; w_wd = wdat; w_pc = wpc;
        s_valid = sv; s_a3 = sa; s_wd = sdat; s_pc = spc;
        q_a1 = a1; q_a2 = a2;
        st.rdy   = (mq.size() < DEPTH);
        st.stall = mstall;
        st.cnt   = mq.size();
        st.b1    = m_busy(a1);
        st.b2    = m_busy(a2);
        wv = we && (wa != 5'd0) && !mstall;
        popped = 0;
        if (wv) begin
            e.a3 = wa; e.wd = wdat; e.pc = wpc;
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            popped = 1;
        end
        st.we = wv || popped;
        st_q.push_back(st);
        if (st.we) exp_q.push_back(e);
        if (st.rdy && sv && sa != 5'd0) begin
            e.a3 = sa; e.wd = sdat; e.pc = spc;
            mq.push_back(e);
        end
        if (popped || st.cnt == 0) mrun = 0;
        else if (wv && mrun < LIM) mrun++;
        mstall = (mrun == LIM);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares status every cycle and each presented write in order.
    always @(negedge clk) begin
        st_t s;
        wr_t e;
        if (st_q.size() != 0) begin
            s = st_q.pop_front();
            chk("s_ready", 32'(s_ready), 32'(s.rdy));
            chk("w_stall", 32'(w_stall), 32'(s.stall));
            chk("q_count", 32'(q_count), 32'(s.cnt));
            chk("q_busy1", 32'(q_busy1), 32'(s.b1));
            chk("q_busy2", 32'(q_busy2), 32'(s.b2));
            chk("rf_we", 32'(rf_we), 32'(s.we));
            if (!rf_we) begin
                chk("rf_a3_idle", 32'(rf_a3), 32'd0);
                chk("rf_wd_idle", rf_wd, 32'd0);
            end
        end
        if (rf_we && reset) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(rf_a3), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rf_a3", 32'(rf_a3), 32'(e.a3));
                chk("rf_wd", rf_wd, e.wd);
                chk("rf_pc", rf_pc, e.pc);
            end
        end
    end

    initial begin
        // Reset held with active requests on both sides.
        reset = 1'b0; w_we = 1'b1; w_a3 = 5'd5; s_valid = 1'b1; s_a3 = 5'd3;
        q_a1 = 5'd3; q_a2 = 5'd5;
        repeat (3) @(negedge clk);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_w_stall", 32'(w_stall), 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_q_busy1", 32'(q_busy1), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        w_we = 1'b0; s_valid = 1'b0;

        // W-stage write, then the ignored r0 write.
        cyc(1, 5, 32'h0000_1234, 32'h100, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'hDEAD_BEEF, 32'h104, 0, 0, 0, 0, 0, 0);
        // Secondary push drains the following cycle.
        cyc(0, 0, 0, 0, 1, 3, 32'hAA, 32'h200, 3, 0);
        idle(2);
        // Fill the FIFO while W owns the port; fifth request must stall.
        for (int i = 0; i < 5; i++)
            cyc(1, 1, 32'h1000 + i, 32'h300 + 4 * i, 1, 5'(10 + i), 32'h5000 + i, 32'h400 + 4 * i, 5'(10 + i), 5'd11);
        for (int i = 0; i < 30; i++)
            cyc(1, 1, 32'h2000 + i, 32'h500 + 4 * i, 0, 0, 0, 0, 12, 13);
        idle(6);
        // Starvation of a single entry.
        cyc(1, 2, 32'h3000, 32'h600, 1, 9, 32'h99, 32'h700, 9, 0);
        for (int i = 0; i < 12; i++)
            cyc(1, 2, 32'h3001 + i, 32'h604 + 4 * i, 0, 0, 0, 0, 9, 2);
        idle(3);
        // Busy query: a3=0 entry is discarded, a3=7 entry stays queued.
        cyc(1, 4, 32'h4000, 32'h800, 1, 7, 32'h77, 32'h900, 0, 0);
        cyc(1, 4, 32'h4001, 32'h804, 1, 0, 32'h00, 32'h904, 7, 0);
        cyc(1, 4, 32'h4002, 32'h808, 0, 0, 0, 0, 7, 0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 800; i++)
            cyc(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        idle(DEPTH + 4);
        repeat (2) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("st_q_drained", 32'(st_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
Shares the register file's single write port between the pipeline W stage and one long-latency secondary writer, such as a multi-cycle MDU or a late load-return path. The W stage has fixed priority. Secondary writes are buffered in a small FIFO and drained when the port is free. A starvation counter forces a one-cycle pipeline stall so the queue cannot wait forever. Pending-write status is reported to the hazard/stall controller. The block sits between the W-stage and MDU result buses and the RF write inputs (A3/WD/WE/W_PC).

Parameters:
DEPTH, 4, secondary FIFO entries (power of 2, minimum 2)
STARVE_LIMIT, 8, consecutive blocked cycles before a forced drain (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
w_we  in  1  W-stage write request
w_a3  in  5  W-stage destination register
w_wd  in  32  W-stage write data
w_pc  in  32  W-stage instruction PC
s_valid  in  1  secondary write request
s_ready  out  1  secondary request accepted this cycle when high together with s_valid
s_a3  in  5  secondary destination register
s_wd  in  32  secondary write data
s_pc  in  32  secondary instruction PC
rf_we  out  1  RF write enable
rf_a3  out  5  RF write address
rf_wd  out  32  RF write data
rf_pc  out  32  PC of the write, for trace
w_stall  out  1  registered; freezes the pipeline for one cycle
q_a1  in  5  hazard query address 1
q_a2  in  5  hazard query address 2
q_busy1  out  1  a queued write targets q_a1
q_busy2  out  1  a queued write targets q_a2
q_count  out  $clog2(DEPTH)+1  number of queued entries

Behaviour:
- Reset (reset=0, asynchronous): FIFO flushed, all pointers and counters 0, w_stall=0, state IDLE. While reset=0: rf_we=0, s_ready=0, q_busy*=0, q_count=0.
- W-stage handshake: no handshake. A W write is valid when w_we=1 and w_a3!=0. A request with w_a3=0 is ignored.
- Secondary handshake: s_ready = !full, derived from registered q_count. A transfer occurs when s_valid=1 and s_ready=1. If s_a3=0, the request is accepted but discarded (not enqueued).
- Grant, combinational, same cycle:
  - If w_stall=0 and a W write is valid, the W stage drives rf_*.
  - Otherwise, if the FIFO is non-empty, the head entry drives rf_* and is popped at the clock edge.
  - Otherwise rf_we=0.
  - When rf_we=0, rf_a3, rf_wd and rf_pc are 0.
- While w_stall=1, the W input is ignored. The pipeline is frozen and re-presents the same instruction in the next cycle.
- No same-cycle bypass: an entry pushed in cycle N is poppable from cycle N+1 at the earliest.
- Push and pop in the same cycle: q_count unchanged. Pointers wrap modulo DEPTH.
- Busy query: q_busyK=1 when any valid FIFO entry has a3==q_aK and q_aK!=0. The hazard controller stalls on q_busy to preserve write order. The arbiter does not reorder writes.
- State machine (registered):
  - IDLE: FIFO empty.
  - DRAIN: non-empty, port free this cycle.
  - BLOCKED: non-empty, W holds the port.
  - FORCE: w_stall=1.
- Transitions:
  - IDLE→DRAIN on the first enqueue.
  - DRAIN→BLOCKED when a W write wins.
  - BLOCKED→DRAIN on a free cycle.
  - BLOCKED→FORCE when starve_cnt reaches STARVE_LIMIT.
  - FORCE→DRAIN or IDLE after exactly one cycle.
  - Any state→IDLE when the FIFO becomes empty.
- starve_cnt (8-bit):
  - Increments each BLOCKED cycle.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- w_stall is high for exactly one cycle per starvation event. In that cycle the head entry is written.

Optional Feature:
RF_WPORT_TRACE_EN
- Defined: on every rising edge with rf_we=1, print "%d@%h: $%d <= %h" using $time, rf_pc, rf_a3, rf_wd. The print is suppressed while reset=0.
- Undefined: no simulation output. Ports and logic are identical either way.

Test Plan:
1. Reset: hold reset=0 with s_valid=1 and w_we=1 → rf_we=0, s_ready=0, w_stall=0, q_count=0. After release → s_ready=1.
2. W write: w_we=1, w_a3=5, w_wd=0x00001234 → same cycle rf_we=1, rf_a3=5, rf_wd=0x00001234. With w_a3=0 → rf_we=0.
3. Drain: push s_a3=3, s_wd=0xAA in cycle N with w_we=0 → cycle N+1: rf_we=1, rf_a3=3, rf_wd=0xAA; q_count goes 1→0.
4. Full: w_we=1 with w_a3=1 held every cycle; push 4 entries (DEPTH=4) → s_ready=0 after the 4th push; a 5th s_valid is not accepted; q_count=4.
5. Starvation: one entry queued (a3=9), w_we=1 continuously → after 8 BLOCKED cycles w_stall=1 for one cycle with rf_a3=9. The next cycle: w_stall=0 and the W write resumes.
6. Busy query: queue entries with a3=7 and a3=0 → q_a1=7 gives q_busy1=1, q_a2=0 gives q_busy2=0 (the a3=0 entry was discarded); q_count=1.
